// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } ifu_state_e;

    // Must match the control-unit next-PC select encoding.
    localparam logic [1:0] NPC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] NPC_SEL_JALR   = 2'd2;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC selection: sequential, branch/jal, or jalr (bit0 cleared).
module npc_gen
    import ifu_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic [63:0] branch_target,
    input  logic [63:0] jalr_target,
    output logic [63:0] npc
);

    always_comb begin
        npc = pc + 64'd4;
        case (npc_sel)
            NPC_SEL_BRANCH: npc = branch_target;
            NPC_SEL_JALR:   npc = {jalr_target[63:1], 1'b0};
            default:        npc = pc + 64'd4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, holds each word until consumed.
// Optional misaligned-PC fault detection is enabled with `define IFU_MISALIGN_CHK_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic [1:0]  npc_sel,
    input  logic [63:0] branch_target,
    input  logic [63:0] jalr_target,
    input  logic        halt,
    output logic        fetch_fault,
    output logic        halted
);

    ifu_state_e  state, state_nxt;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [63:0] pc_nxt;
    logic        handshake;
    logic        misalign;
    logic        resp_take;

    npc_gen u_npc_gen (
        .pc            (pc),
        .npc_sel       (npc_sel),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .npc           (npc)
    );

`ifdef IFU_MISALIGN_CHK_EN
    assign misalign = |npc[1:0];
    assign pc_nxt   = npc;
`else
    assign misalign = 1'b0;
    assign pc_nxt   = npc & ~64'h3;
`endif

    assign handshake     = (state == ST_HOLD) && instr_ready;
    assign resp_take     = (state == ST_WAIT) && imem_resp_valid;
    assign imem_req_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid) state_nxt = imem_resp_err ? ST_HALTED : ST_HOLD;
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) state_nxt = (halt || misalign) ? ST_HALTED : ST_REQ;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (resp_take) begin
                if (imem_resp_err) begin
                    fetch_fault <= 1'b1;
                    halted      <= 1'b1;
                end else begin
                    instr    <= imem_resp_data;
                    instr_pc <= pc;
                end
            end
            if (handshake) begin
                pc <= pc_nxt;
                if (halt || misalign) halted <= 1'b1;
                if (misalign) fetch_fault <= 1'b1;
            end
        end
    end

endmodule
